// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: issue/result bundle between the EX stage and the multiply/divide unit.
//   master (EX side)  drives start, op, src_a, src_b, cancel; observes busy, done, hi, lo.
//   slave  (mdu_hilo) observes the issue signals; drives busy, done, hi, lo.
interface mdu_hilo_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
//   clk, rst : single clock, synchronous active-high reset.
//   bus      : mdu_hilo_if.slave
//     start/op/src_a/src_b : op issue from EX (op: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                            5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, others no-op)
//     cancel               : exception flush, aborts the in-flight op and any same-cycle start
//     busy                 : registered, high while an op is in flight
//     done                 : one-cycle pulse after a multiply/divide result lands in HI/LO
//     hi/lo                : HI/LO register outputs
// Optional feature: define MDU_MADD_EN to build MADD/MADDU (64-bit accumulate into HI/LO).
// Without it, op codes 7/8 are plain no-ops.
module mdu_hilo #(
  parameter int DIV_ITER = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  localparam int CW = $clog2(DIV_ITER + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_DIV  = 3'd3,
    S_DFIX = 3'd4
  } state_t;

  state_t        state_q, state_d;
  // a_q: multiplicand, or dividend that shifts out while quotient bits shift in.
  // b_q: multiplier, or divisor magnitude.
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   rem_q, rem_d;
  logic [63:0]   prod_q, prod_d;
  logic          sgn_q, sgn_d;     // signed multiply
  logic          qneg_q, qneg_d;   // negate quotient in DFIX
  logic          rneg_q, rneg_d;   // negate remainder in DFIX
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef MDU_MADD_EN
  logic          acc_q, acc_d;     // accumulate product into {HI,LO}
`endif

  // Low 64 bits of the product of the extended operands are correct for both
  // signed and unsigned multiplies.
  logic [63:0] ext_a, ext_b, mul_res;
  assign ext_a   = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b   = {{32{sgn_q & b_q[31]}}, b_q};
  assign mul_res = ext_a * ext_b;

  // One restoring step: shift the next dividend bit into the partial remainder.
  // rem_q < divisor, so rem_sh fits 33 bits and any successful subtraction
  // result fits 32 bits. With a zero divisor every step "succeeds", giving an
  // all-ones quotient and the dividend as remainder.
  logic [32:0] rem_sh;
  logic        step_ok;
  assign rem_sh  = {rem_q, a_q[31]};
  assign step_ok = (rem_sh >= {1'b0, b_q});

  // A new op may be accepted in IDLE or on the final (write) cycle of an op,
  // so back-to-back issue needs no idle gap.
  logic can_start;
  assign can_start = (state_q == S_IDLE) || (state_q == S_MUL2) || (state_q == S_DFIX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
`endif

    case (state_q)
      S_MUL1: begin
        prod_d  = mul_res;
        state_d = S_MUL2;
      end
      S_MUL2: begin
`ifdef MDU_MADD_EN
        if (acc_q) begin
          {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
        end else begin
          {hi_d, lo_d} = prod_q;
        end
`else
        {hi_d, lo_d} = prod_q;
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DIV: begin
        if (step_ok) begin
          rem_d = rem_sh[31:0] - b_q;
          a_d   = {a_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          a_d   = {a_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DIV_ITER - 1)) begin
          state_d = S_DFIX;
        end
      end
      S_DFIX: begin
        lo_d    = qneg_q ? (~a_q + 32'd1) : a_q;
        hi_d    = rneg_q ? (~rem_q + 32'd1) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // Issue decode comes after the state actions so that an MTHI/MTLO issued
    // on a final write cycle (later in program order) wins over the result.
    if (bus.start && can_start) begin
      case (bus.op)
        OP_MULT, OP_MULTU: begin
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          sgn_d   = (bus.op == OP_MULT);
`ifdef MDU_MADD_EN
          acc_d   = 1'b0;
`endif
          state_d = S_MUL1;
        end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: begin
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          sgn_d   = (bus.op == OP_MADD);
          acc_d   = 1'b1;
          state_d = S_MUL1;
        end
`endif
        OP_DIV: begin
          a_d     = bus.src_a[31] ? (~bus.src_a + 32'd1) : bus.src_a;
          b_d     = bus.src_b[31] ? (~bus.src_b + 32'd1) : bus.src_b;
          qneg_d  = bus.src_a[31] ^ bus.src_b[31];
          rneg_d  = bus.src_a[31];
          rem_d   = 32'd0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
        OP_DIVU: begin
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          rem_d   = 32'd0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
        OP_MTHI: hi_d = bus.src_a;
        OP_MTLO: lo_d = bus.src_a;
        default: ;
      endcase
    end

    // A faulting instruction must leave no HI/LO side effect: abort everything,
    // including a result write or a start in this same cycle.
    if (bus.cancel) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      prod_q  <= 64'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      prod_q  <= prod_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed bench for mdu_hilo. Expected {HI,LO} results are pushed
// into a scoreboard queue at issue time; a monitor pops one entry per done pulse.
// Busy lengths, cancel, reset and MT writes are checked inline.
module tb_mdu_hilo;
  logic clk;
  logic rst;

  mdu_hilo_if bus ();

  mdu_hilo #(.DIV_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done with hi=%h lo=%h, required no done", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.hi, bus.lo} !== e) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, e[63:32], e[31:0]);
        end else begin
          $display("txn done: hi=%h lo=%h", bus.hi, bus.lo);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    $display("txn issue: op=%0d a=%h b=%h", o, a, b);
  endtask

  // Counts negedges with busy high, stopping at the first low one (bounded).
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else return;
    end
    checks++;
    errors++;
    $display("FAIL busy_timeout: busy still high after %0d cycles, required to fall", n);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    issue(o, v, 32'd0);
    @(negedge clk);
    check("mt_busy", {63'd0, bus.busy}, 64'd0);
    if (o == OP_MTHI) check("mthi", {32'd0, bus.hi}, {32'd0, v});
    else              check("mtlo", {32'd0, bus.lo}, {32'd0, v});
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 4'd0;
    bus.src_a  = 32'd0;
    bus.src_b  = 32'd0;
    bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;

    // MULT -3 * 5
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    count_busy(n);
    check("mult_busy_cycles", 64'(n), 64'd2);

    // DIVU 100 / 7
    exp_q.push_back({32'd2, 32'd14});
    issue(OP_DIVU, 32'd100, 32'd7);
    count_busy(n);
    check("divu_busy_cycles", 64'(n), 64'd33);

    // DIVU by zero
    exp_q.push_back({32'h12345678, 32'hFFFFFFFF});
    issue(OP_DIVU, 32'h12345678, 32'd0);
    count_busy(n);

    // DIV -7 / 2 and 7 / -2
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    check("div_busy_cycles", 64'(n), 64'd33);
    exp_q.push_back({32'h00000001, 32'hFFFFFFFD});
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    count_busy(n);

    // Cancel in the middle of a divide
    mt(OP_MTHI, 32'h11111111);
    mt(OP_MTLO, 32'h22222222);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("cancel_mid_hilo", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});

    // Cancel in the DFIX cycle
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(negedge clk);
    @(negedge clk);
    check("dfix_busy_before_cancel", {63'd0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_dfix_busy", {63'd0, bus.busy}, 64'd0);
    check("cancel_dfix_hilo", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});

    // Cancel together with an MTHI in IDLE drops the write
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = OP_MTHI;
    bus.src_a  = 32'hDEADBEEF;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_mthi_hi", {32'd0, bus.hi}, {32'd0, 32'h11111111});

    // Unused op code is a no-op
    issue(4'd0, 32'h55555555, 32'h66666666);
    @(negedge clk);
    check("noop_busy", {63'd0, bus.busy}, 64'd0);
    check("noop_hilo", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});

    // MTLO pulsed mid-multiply is ignored
    exp_q.push_back({32'd0, 32'd12});
    issue(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MTLO;
    bus.src_a = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    count_busy(n);
    check("mult_ignore_start_lo", {32'd0, bus.lo}, 64'd12);

    // DIVU issued on the edge busy falls after a MULTU
    exp_q.push_back({32'd0, 32'd6});
    exp_q.push_back({32'd2, 32'd14});
    issue(OP_MULTU, 32'd2, 32'd3);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    count_busy(n);
    check("restart_div_busy_cycles", 64'(n), 64'd33);

    // Accumulate ops
    mt(OP_MTHI, 32'h00000000);
    mt(OP_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    exp_q.push_back({32'h00000001, 32'h00000000});
    issue(OP_MADDU, 32'd1, 32'd1);
    count_busy(n);
    check("maddu_busy_cycles", 64'(n), 64'd2);
    exp_q.push_back({32'h00000000, 32'hFFFFFFFF});
    issue(OP_MADD, 32'hFFFFFFFF, 32'd1);
    count_busy(n);
`else
    issue(OP_MADDU, 32'd1, 32'd1);
    @(negedge clk);
    check("maddu_off_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("maddu_off_hilo", {bus.hi, bus.lo}, {32'h00000000, 32'hFFFFFFFF});
`endif

    // Reset in the middle of a divide
    mt(OP_MTHI, 32'h00000005);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", {63'd0, bus.busy}, 64'd0);
    check("midreset_done", {63'd0, bus.done}, 64'd0);
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
